dma_controller: RTL and testbench
=================================

DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports: clk  in  1  rising-edge clock; reset_n  in  1  async active-low reset.
REQ-002 SHALL have cmd_valid  in  1  CPU start pulse; cmd_addr  in  16  memory base word address.
REQ-003 SHALL have br  out  1  bus request to CPU; bg  in  1  bus grant from CPU.
REQ-004 SHALL have offset  out  2  device block select; dev_data  in  64  device block, four 16-bit words.
REQ-005 SHALL have mem_addr  out  16  write address; mem_data  out  16  write data; mem_write  out  1  write strobe; mem_ready  in  1  memory accepts the current word.
REQ-006 SHALL have busy  out  1  transfer in progress; done_int  out  1  completion interrupt to CPU.
REQ-007 SHALL use the fixed parameter BLOCKS = 3 (device blocks) and WORDS = 4 (words per block), for 12 words per command.

Function
REQ-008 SHALL implement the states IDLE, REQ, XFER, STEAL and DONE.
REQ-009 In IDLE, SHALL latch cmd_addr, clear blk and word to 0 and enter REQ on a clock edge where cmd_valid=1.
REQ-010 In REQ, SHALL drive br=1 and enter XFER on the first edge with bg=1; br=1 is already visible in the cycle after cmd_valid.
REQ-011 In XFER, SHALL drive br=1, offset=blk, mem_addr=base+4*blk+word (mod 2^16), mem_data=dev_data[16*word+15:16*word] (word 0 is least significant) and mem_write=bg (combinational).
REQ-012 In XFER, SHALL increment word on an edge with bg=1 and mem_ready=1; when word=3, SHALL wrap word to 0 and increment blk.
REQ-013 SHALL leave XFER for DONE when the word with blk=2, word=3 is accepted; a block boundary that is not the last block SHALL leave XFER only as given in REQ-023.
REQ-014 If bg drops in XFER, SHALL clear mem_write in the same cycle, freeze blk, word and base, and enter REQ with br still 1; on re-grant, the transfer SHALL resume at the same word.
REQ-015 In DONE, SHALL drive br=0 and done_int=1 for exactly one cycle, then enter IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 cmd_valid SHALL be ignored when not in IDLE, including in the DONE cycle.
REQ-018 Outside XFER, SHALL drive offset=3 (device tri-states its data) and mem_write=0.
REQ-019 A base address near 16'hFFFF SHALL wrap modulo 2^16 with no error indication.
REQ-020 In any state, mem_ready=1 while mem_write=0 SHALL have no effect.

Reset
REQ-021 On reset_n=0, SHALL enter IDLE immediately and set br=0, offset=3, mem_addr=0, mem_data=0, mem_write=0, busy=0, done_int=0, and blk, word and base to 0.
REQ-022 Reset during a transfer SHALL abandon it without asserting done_int; words already written SHALL NOT be rolled back.

Configuration
REQ-023 The macro DMA_CYCLE_STEAL_EN SHALL select between two modes.
- Defined: after a non-final block completes, the controller SHALL enter STEAL, drive br=0 for exactly one cycle, then enter REQ (bus re-arbitrated per block).
- Undefined: the controller SHALL stay in XFER across block boundaries (burst mode), br SHALL stay 1 for all 12 words, and STEAL SHALL be unreachable.

Verification
REQ-024 Burst mode: cmd_addr=16'h0100, bg=1 one cycle after br rises, mem_ready always 1 -> 12 consecutive writes to addresses 0x0100..0x010B, offsets 0,0,0,0,1,...,2, then done_int pulses 1 cycle and busy falls.
REQ-025 Data order: dev_data=64'h4444_3333_2222_1111 at offset 0 -> writes 1111, 2222, 3333, 4444 to base+0..base+3.
REQ-026 Back-pressure: mem_ready low for 3 cycles on word 5 -> mem_addr and mem_data hold for 4 cycles; no skipped or duplicate address.
REQ-027 Grant loss: bg dropped after word 6 for 5 cycles -> mem_write=0 in the same cycle, br stays 1, resume at base+7; total writes = 12.
REQ-028 With DMA_CYCLE_STEAL_EN: br falls for exactly 1 cycle after words 3 and 7 and not after word 11; with base=16'hFFFC, addresses wrap to 0x0000..0x0007.
REQ-029 reset_n pulsed low mid-block, then cmd_valid ignored while busy -> all outputs at reset values asynchronously, no done_int, and the next command restarts at word 0.

Source files
------------

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - three-block, four-word device-to-memory DMA engine with bus request/grant.
// Define DMA_CYCLE_STEAL_EN to release the bus for one cycle between blocks; default is burst mode.
module dma_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_addr,
    output logic        br,
    input  logic        bg,
    output logic [1:0]  offset,
    input  logic [63:0] dev_data,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_write,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done_int
);
    localparam int BLOCKS = 3;
    localparam int WORDS  = 4;
    localparam logic [1:0] LAST_BLK  = 2'(BLOCKS - 1);
    localparam logic [1:0] LAST_WORD = 2'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        STEAL,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [1:0]  blk_q, blk_d;
    logic [1:0]  word_q, word_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= 16'd0;
            blk_q   <= 2'd0;
            word_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            blk_q   <= blk_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        blk_d     = blk_q;
        word_d    = word_q;
        br        = 1'b0;
        offset    = 2'd3;
        mem_addr  = 16'd0;
        mem_data  = 16'd0;
        mem_write = 1'b0;
        done_int  = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    base_d  = cmd_addr;
                    blk_d   = 2'd0;
                    word_d  = 2'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                br = 1'b1;
                if (bg) state_d = XFER;
            end
            XFER: begin
                br        = 1'b1;
                offset    = blk_q;
                mem_addr  = base_q + {12'd0, blk_q, 2'b00} + {14'd0, word_q};
                mem_data  = dev_data[{word_q, 4'b0000} +: 16];
                mem_write = bg;
                // Losing the grant parks in REQ with position frozen so the same word is retried.
                if (!bg) begin
                    state_d = REQ;
                end else if (mem_ready) begin
                    if (word_q == LAST_WORD) begin
                        word_d = 2'd0;
                        if (blk_q == LAST_BLK) begin
                            state_d = DONE;
                        end else begin
                            blk_d = blk_q + 2'd1;
`ifdef DMA_CYCLE_STEAL_EN
                            state_d = STEAL;
`endif
                        end
                    end else begin
                        word_d = word_q + 2'd1;
                    end
                end
            end
            STEAL: begin
                state_d = REQ;
            end
            DONE: begin
                done_int = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - vector-table and scoreboard bench for dma_controller.
module tb_dma_controller;
    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic        br;
    logic        bg;
    logic [1:0]  offset;
    logic [63:0] dev_data;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_write;
    logic        mem_ready;
    logic        busy;
    logic        done_int;

    int checks = 0;
    int errors = 0;

`ifdef DMA_CYCLE_STEAL_EN
    localparam int EXP_BR_LOW = 2;
`else
    localparam int EXP_BR_LOW = 0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  off;
    } exp_t;

    typedef struct {
        logic [15:0] base;
        int          stall_word;
        int          stall_len;
        int          drop_word;
        int          drop_len;
        bit          rand_ready;
        bit          poke;
        int          abort_at;
        int          exp_writes;
        int          exp_br_low;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    dma_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_addr  (cmd_addr),
        .br        (br),
        .bg        (bg),
        .offset    (offset),
        .dev_data  (dev_data),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_write (mem_write),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done_int  (done_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dev_word(input int b, input int w);
        return 16'(16'h1111 * (w + 1)) ^ 16'(16'h0100 * b);
    endfunction

    always_comb begin
        dev_data = {dev_word(int'(offset), 3), dev_word(int'(offset), 2),
                    dev_word(int'(offset), 1), dev_word(int'(offset), 0)};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_br", br, 1'b0);
        chk("rst_offset", offset, 2'd3);
        chk("rst_mem_addr", mem_addr, 16'd0);
        chk("rst_mem_data", mem_data, 16'd0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_int", done_int, 1'b0);
    endtask

    task automatic run_case(input vec_t v);
        int widx = 0, cyc = 0, done_cnt = 0, br_low = 0, hold = 0;
        int stall_done = 0, drop_rem = 0;
        bit prev_br = 0, seen_done = 0, finished = 0, poke_next = 0, drop_now;
        exp_t e;

        for (int i = 0; i < 12; i++) begin
            e.addr = 16'(v.base + 16'(i));
            e.data = dev_word(i / 4, i % 4);
            e.off  = 2'(i / 4);
            sb.push_back(e);
        end

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = v.base;
        bg        = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = ~v.base;

        while (!finished && cyc < 400) begin
            cyc++;
            cmd_valid = poke_next;
            cmd_addr  = 16'h7777;
            poke_next = 0;
            drop_now  = (drop_rem > 0);
            if (drop_now) begin
                bg = 1'b0;
                drop_rem--;
            end else begin
                bg = prev_br;
            end
            if (v.stall_word == widx && stall_done < v.stall_len) mem_ready = 1'b0;
            else if (v.rand_ready) mem_ready = 1'($urandom_range(0, 1));
            else mem_ready = 1'b1;
            #1;
            if (cyc == 1) chk("br_after_cmd", br, 1'b1);
            if (seen_done) begin
                chk("busy_after_done", busy, 1'b0);
                chk("done_width", done_int, 1'b0);
                finished = 1;
            end else begin
                if (!bg) chk("write_without_grant", mem_write, 1'b0);
                if (drop_now) chk("br_during_drop", br, 1'b1);
                if (!br && !done_int) br_low++;
                if (mem_write) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_write", mem_addr, 16'hxxxx);
                    end else begin
                        chk("mem_addr", mem_addr, sb[0].addr);
                        chk("mem_data", mem_data, sb[0].data);
                        chk("offset", offset, sb[0].off);
                    end
                    if (widx == v.stall_word) hold++;
                    if (!mem_ready) begin
                        if (widx == v.stall_word) stall_done++;
                    end else begin
                        if (sb.size() != 0) void'(sb.pop_front());
                        widx++;
                        if (widx - 1 == v.drop_word) drop_rem = v.drop_len;
                        if (v.poke && (widx == 3 || widx == 12)) poke_next = 1;
                        if (widx == v.abort_at) begin
                            chk("no_done_before_abort", done_cnt, 0);
                            return;
                        end
                    end
                end
                if (done_int) begin
                    done_cnt++;
                    chk("br_in_done", br, 1'b0);
                    chk("busy_in_done", busy, 1'b1);
                    seen_done = 1;
                end
            end
            prev_br = br;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        bg        = 1'b0;

        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout: transfer not complete after %0d cycles, %0d writes", cyc, widx);
        end
        chk("writes", widx, v.exp_writes);
        chk("done_pulses", done_cnt, 1);
        chk("br_low_cycles", br_low, v.exp_br_low);
        chk("sb_empty", sb.size(), 0);
        if (v.stall_word >= 0) chk("stall_hold", hold, v.stall_len + 1);
    endtask

    task automatic reset_mid_transfer();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        cmd_valid = 1'b1;
        cmd_addr  = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        chk("busy_in_reset", busy, 1'b0);
        chk("done_in_reset", done_int, 1'b0);
        cmd_valid = 1'b0;
        bg        = 1'b0;
        reset_n   = 1'b1;
        sb.delete();
    endtask

    initial begin
        //           base      stall  len drop  len rnd poke abort wr  brlow
        vecs[0] = '{16'h0100, -1, 0, -1, 0, 1'b0, 1'b0, -1, 12, EXP_BR_LOW};
        vecs[1] = '{16'h0100,  5, 3, -1, 0, 1'b0, 1'b0, -1, 12, EXP_BR_LOW};
        vecs[2] = '{16'h0300, -1, 0,  6, 5, 1'b0, 1'b0, -1, 12, EXP_BR_LOW};
        vecs[3] = '{16'hFFFC, -1, 0, -1, 0, 1'b0, 1'b0, -1, 12, EXP_BR_LOW};
        vecs[4] = '{16'h1234, -1, 0, -1, 0, 1'b1, 1'b0, -1, 12, EXP_BR_LOW};
        vecs[5] = '{16'h0040, -1, 0, -1, 0, 1'b0, 1'b1, -1, 12, EXP_BR_LOW};
        vecs[6] = '{16'h0500, -1, 0, -1, 0, 1'b0, 1'b0,  5, 12, EXP_BR_LOW};
        vecs[7] = '{16'h0200, -1, 0, -1, 0, 1'b0, 1'b0, -1, 12, EXP_BR_LOW};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 16'h0000;
        bg        = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_case(vecs[i]);
            if (vecs[i].abort_at >= 0) reset_mid_transfer();
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
